// File: rtl/gmii_rx_deframer_if.sv
// gmii_rx_deframer_if
//   Bundles the GMII receive byte stream and the deframed output stream
//   for gmii_rx_deframer.
//   slave  : deframer side (consumes gmii_*, drives m_*)
//   master : environment side (drives gmii_*, consumes m_*)
// Signals:
//   gmii_dv_i   data valid from the MAC TX side
//   gmii_d_i    data byte, sampled while gmii_dv_i=1
//   m_data_o    frame byte, valid while m_valid_o=1
//   m_valid_o   one-cycle strobe per output byte
//   m_sof_o     first byte of frame (DA byte 0)
//   m_eof_o     last non-FCS byte of frame
//   m_err_o     with m_eof_o: frame is bad (CRC, runt or oversize)
interface gmii_rx_deframer_if;
  logic       gmii_dv_i;
  logic [7:0] gmii_d_i;
  logic [7:0] m_data_o;
  logic       m_valid_o;
  logic       m_sof_o;
  logic       m_eof_o;
  logic       m_err_o;

  modport slave (
    input  gmii_dv_i, gmii_d_i,
    output m_data_o, m_valid_o, m_sof_o, m_eof_o, m_err_o
  );

  modport master (
    output gmii_dv_i, gmii_d_i,
    input  m_data_o, m_valid_o, m_sof_o, m_eof_o, m_err_o
  );
endinterface

// File: rtl/gmii_rx_deframer.sv
// gmii_rx_deframer
//   Receive-side deframer. Strips preamble/SFD, holds back and removes the
//   4-byte FCS through a 5-deep delay line, checks length (MIN_LEN..MAX_LEN,
//   DA through FCS) and optionally CRC-32, and flags frame boundaries/errors.
//   Keeps wrapping 16-bit good/bad frame counters.
// Configuration macro:
//   GMII_RX_CRC_CHECK_EN  defined: CRC-32 checked and reported in m_err_o.
//                         undefined: no CRC logic, only runt/oversize flagged.
// Ports:
//   clk_i            clock, rising edge
//   rst_n_i          asynchronous active-low reset
//   bus              gmii_rx_deframer_if.slave (GMII in, frame stream out)
//   frame_ok_cnt_o   good frame counter (wraps)
//   frame_err_cnt_o  bad/dropped frame counter (wraps)
module gmii_rx_deframer #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  gmii_rx_deframer_if.slave    bus,
  output logic [15:0]          frame_ok_cnt_o,
  output logic [15:0]          frame_err_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_DROP
  } state_e;

  localparam logic [7:0]  PRE_B = 8'h55;
  localparam logic [7:0]  SFD_B = 8'hD5;
  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);

  state_e          state_q, state_d;
  // Set by reset; a frame already in flight when reset releases is dropped.
  logic            first_q;
  // Delay line: entry 0 is the oldest byte.
  logic [4:0][7:0] line_q, line_d;
  logic [2:0]      fill_q, fill_d;
  logic [10:0]     len_q, len_d;
  logic            sof_pend_q, sof_pend_d;

  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            sof_q, sof_d;
  logic            eof_q, eof_d;
  logic            err_q, err_d;
  logic [15:0]     ok_cnt_q, ok_cnt_d;
  logic [15:0]     err_cnt_q, err_cnt_d;

  logic            len_bad;
  logic            crc_bad;

  wire             dv = bus.gmii_dv_i;
  wire  [7:0]      db = bus.gmii_d_i;

`ifdef GMII_RX_CRC_CHECK_EN
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  logic [31:0] crc_q, crc_d;

  // Reflected CRC-32 (0x04C11DB7 bit-reversed), one byte LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c,
                                             input logic [7:0]  b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int unsigned i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign crc_bad = (crc_q != CRC_RESIDUE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) crc_q <= '0;
    else          crc_q <= crc_d;
  end
`else
  assign crc_bad = 1'b0;
`endif

  assign len_bad = (len_q < MIN_L) || (len_q > MAX_L);

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (dv) begin
          if (first_q)           state_d = S_DROP;
          else if (db == PRE_B)  state_d = S_PREAMBLE;
          else if (db == SFD_B)  state_d = S_DATA;
          else                   state_d = S_DROP;
        end
      end
      S_PREAMBLE: begin
        if (!dv)                 state_d = S_IDLE;
        else if (db == SFD_B)    state_d = S_DATA;
        else if (db != PRE_B)    state_d = S_DROP;
      end
      S_DATA:  if (!dv) state_d = S_IDLE;
      S_DROP:  if (!dv) state_d = S_IDLE;
      default:          state_d = S_IDLE;
    endcase
  end

  // Output and datapath next-state logic
  always_comb begin
    line_d     = line_q;
    fill_d     = fill_q;
    len_d      = len_q;
    sof_pend_d = sof_pend_q;
    data_d     = '0;
    valid_d    = 1'b0;
    sof_d      = 1'b0;
    eof_d      = 1'b0;
    err_d      = 1'b0;
    ok_cnt_d   = ok_cnt_q;
    err_cnt_d  = err_cnt_q;
`ifdef GMII_RX_CRC_CHECK_EN
    crc_d      = crc_q;
`endif
    case (state_q)
      S_IDLE, S_PREAMBLE: begin
        if (state_d == S_DATA) begin
          line_d     = '0;
          fill_d     = '0;
          len_d      = '0;
          sof_pend_d = 1'b1;
`ifdef GMII_RX_CRC_CHECK_EN
          crc_d      = '1;
`endif
        end else if (state_d == S_DROP && !first_q) begin
          // Fragment left over from a reset abort is not counted as a frame.
          err_cnt_d = err_cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (dv) begin
          len_d = (len_q == '1) ? len_q : len_q + 11'd1;
`ifdef GMII_RX_CRC_CHECK_EN
          crc_d = crc32_byte(crc_q, db);
`endif
          if (fill_q == 3'd5) begin
            data_d     = line_q[0];
            valid_d    = 1'b1;
            sof_d      = sof_pend_q;
            sof_pend_d = 1'b0;
            line_d     = {db, line_q[4:1]};
          end else begin
            line_d[fill_q] = db;
            fill_d         = fill_q + 3'd1;
          end
        end else begin
          // dv fall: the four newest bytes are the FCS and are discarded.
          if (fill_q == 3'd5) begin
            data_d  = line_q[0];
            valid_d = 1'b1;
            sof_d   = sof_pend_q;
            eof_d   = 1'b1;
            err_d   = len_bad || crc_bad;
            if (len_bad || crc_bad) err_cnt_d = err_cnt_q + 16'd1;
            else                    ok_cnt_d  = ok_cnt_q + 16'd1;
          end else begin
            err_cnt_d = err_cnt_q + 16'd1;
          end
          line_d     = '0;
          fill_d     = '0;
          sof_pend_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      first_q    <= 1'b1;
      line_q     <= '0;
      fill_q     <= '0;
      len_q      <= '0;
      sof_pend_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      err_q      <= 1'b0;
      ok_cnt_q   <= '0;
      err_cnt_q  <= '0;
    end else begin
      first_q    <= 1'b0;
      line_q     <= line_d;
      fill_q     <= fill_d;
      len_q      <= len_d;
      sof_pend_q <= sof_pend_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      err_q      <= err_d;
      ok_cnt_q   <= ok_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.m_data_o    = data_q;
  assign bus.m_valid_o   = valid_q;
  assign bus.m_sof_o     = sof_q;
  assign bus.m_eof_o     = eof_q;
  assign bus.m_err_o     = err_q;
  assign frame_ok_cnt_o  = ok_cnt_q;
  assign frame_err_cnt_o = err_cnt_q;

endmodule

// File: doc/gmii_rx_deframer.md
# gmii_rx_deframer

Receive-side deframer that consumes the byte-wide GMII/MII transmit stream produced by the MAC model (`dv` + 8-bit data) and turns it into a clean frame stream for the bridge core. It strips preamble/SFD, holds back and removes the 4-byte FCS, checks length and CRC-32, and marks frame boundaries and errors. It also keeps good/bad frame counters.

## Interface
- `MIN_LEN`, 64: minimum legal frame length in bytes, destination address through FCS inclusive.
- `MAX_LEN`, 1518: maximum legal frame length in bytes, same span.
- `clk_i` input 1: single clock; all logic on its rising edge.
- `rst_n_i` input 1: reset, asynchronous, active-low.
- `gmii_dv_i` input 1: data valid from the MAC TX side.
- `gmii_d_i` input 8: data byte, sampled when `gmii_dv_i`=1.
- `m_data_o` output 8: frame byte, valid when `m_valid_o`=1.
- `m_valid_o` output 1: one-cycle strobe per output byte.
- `m_sof_o` output 1: first byte of frame (destination address byte 0).
- `m_eof_o` output 1: last non-FCS byte of frame.
- `m_err_o` output 1: with `m_eof_o`, frame is bad (CRC, runt, or oversize).
- `frame_ok_cnt_o` output 16: good frames, wraps at 0xFFFF→0.
- `frame_err_cnt_o` output 16: bad/dropped frames, wraps.

## Operation
- FSM states: IDLE, PREAMBLE, DATA, DROP.
  - IDLE: `dv`=1 and byte 0x55 → PREAMBLE. `dv`=1 and byte 0xD5 → DATA (no preamble tolerated). Any other byte → DROP.
  - PREAMBLE: 0x55 stays; 0xD5 → DATA; any other byte → DROP; `dv`=0 → IDLE with no count change.
  - DATA: each byte enters a 5-deep delay line and the length counter (11-bit, saturates at 2047).
    - Once the line holds 5 bytes, each new byte pushes out the oldest as an output beat. The first beat carries `m_sof_o`.
    - On `dv`=0 the line holds the last 5 bytes. The oldest is emitted with `m_eof_o`; the 4 FCS bytes are discarded. → IDLE.
  - DROP: discard until `dv`=0 → IDLE. Increment `frame_err_cnt_o` once per dropped frame.
- Error at EOF: `m_err_o`=1 if length < `MIN_LEN`, length > `MAX_LEN`, or CRC fails.
  - Oversize frames are still forwarded in full; only the EOF flag reports the error.
- Runt below 5 bytes after SFD: nothing is emitted, `frame_err_cnt_o` increments, → IDLE.
- CRC-32 (IEEE 802.3 polynomial 0x04C11DB7):
  - Reflected/LSB-first, initialised to 0xFFFFFFFF at SFD.
  - Updated over every post-SFD byte, FCS included.
  - Frame passes when the register equals the residue 0xDEBB20E3 at `dv` fall.
- Counters update on the EOF beat: `frame_ok_cnt_o` if `m_err_o`=0, else `frame_err_cnt_o`.
- A `dv`=1 byte arriving in the cycle right after `dv` fall is processed from IDLE normally (zero IPG tolerated).

## Timing
- Reset values: all outputs 0, counters 0, state IDLE, delay line cleared.
- Reset assertion mid-frame aborts it at once. No EOF is emitted and no counter increments.
- If `gmii_dv_i`=1 at the first edge after reset release, enter DROP, never DATA mid-frame.
- Latency: post-SFD byte *i* (sampled at edge *k*) is output in the cycle after the edge that samples byte *i*+5.
- The EOF beat is registered at the edge that samples `dv`=0. `m_err_o` and the counters are valid in that same cycle.
- All outputs are registered. `m_sof_o`, `m_eof_o`, and `m_err_o` are only ever 1 when `m_valid_o`=1.
- No backpressure: the consumer must accept one byte per cycle.
- For a 5-byte frame, `m_sof_o` and `m_eof_o` assert on the same beat.

## Configuration
- Macro `GMII_RX_CRC_CHECK_EN`.
  - Defined: CRC logic is present and a CRC failure sets `m_err_o`.
  - Undefined: no CRC logic. `m_err_o` reflects only runt/oversize, and the FCS is still stripped.

## Test plan
- 7×0x55, 0xD5, 60 bytes 0x00..0x3B, correct FCS → 60 beats with data 0x00..0x3B. SOF on 0x00, EOF on 0x3B, `m_err_o`=0, `frame_ok_cnt_o`=1.
- Same frame with FCS byte 0 XOR 0x01 → identical data, EOF with `m_err_o`=1, `frame_err_cnt_o`=1. Without the macro, `m_err_o`=0.
- Preamble 0x55,0x55,0x11 then data → no beats, `frame_err_cnt_o`+1. A following good frame with zero IPG → received OK.
- SFD then 3 bytes, `dv` low → no beats, `frame_err_cnt_o`+1. SFD + 20 bytes with valid CRC → 16 beats, EOF `m_err_o`=1 (runt).
- 1600-byte frame with valid CRC → 1596 beats, EOF `m_err_o`=1. Length counter does not wrap.
- Assert `rst_n_i` for 2 cycles at data byte 30 with `dv` held high → outputs 0 immediately. Remainder of frame dropped with no beats, then the next good frame is received OK.
